md_sched: RTL and testbench

//  Multi-cycle multiply/divide scheduler for the E stage of the 5-stage MIPS pipeline.
//  - Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per start pulse.
//  - Models unit latency with a down-counter and owns the HI/LO registers.
//  - Raises md_stall so D-stage HI/LO users wait; this adds to the Tuse/Tnew stall.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_alu.sv | 73 +++++++
 rtl/md_sched.sv | 110 +++++++++++
 tb/tb_md_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide scheduler.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    localparam int MUL_CYC_DEF = 5;
    localparam int DIV_CYC_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    // Ops that occupy the unit for a multi-cycle run.
    function automatic logic is_run_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational HI/LO result generator: products, quotients/remainders and MTHI/MTLO moves.
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi_val,
    input  logic [31:0] lo_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    md_op_e             op;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    assign op       = md_op_e'(md_op);
    assign prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    assign div_zero = (rt_val == 32'd0);
    assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    // The only signed quotient that does not fit is MIN_INT / -1; it wraps to MIN_INT with zero remainder.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (!div_zero) begin
            quo_u = rs_val / rt_val;
            rem_u = rs_val % rt_val;
            if (div_ovf) begin
                quo_s = $signed(rs_val);
                rem_s = '0;
            end else begin
                quo_s = $signed(rs_val) / $signed(rt_val);
                rem_s = $signed(rs_val) % $signed(rt_val);
            end
        end
    end

    always_comb begin
        res_hi = hi_val;
        res_lo = lo_val;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (!div_zero) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MD_DIVU: begin
                if (!div_zero) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            MD_MTHI:  res_hi = rs_val;
            MD_MTLO:  res_lo = rs_val;
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler: latency counter, HI/LO ownership and D-stage stall request.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_CYC = MUL_CYC_DEF,
    parameter int DIV_CYC = DIV_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        D_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    md_op_e      op;

    assign op = md_op_e'(md_op);

    md_alu u_alu (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_val (hi_reg),
        .lo_val (lo_reg),
        .res_hi (alu_hi),
        .res_lo (alu_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            state_next   = ST_MUL_RUN;
                            cnt_next     = CNT_W'(MUL_CYC - 1);
                            pend_hi_next = alu_hi;
                            pend_lo_next = alu_lo;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_next   = ST_DIV_RUN;
                            cnt_next     = CNT_W'(DIV_CYC - 1);
                            pend_hi_next = alu_hi;
                            pend_lo_next = alu_lo;
                        end
                        MD_MTHI: hi_next = alu_hi;
                        MD_MTLO: lo_next = alu_lo;
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    hi_next    = pend_hi_reg;
                    lo_next    = pend_lo_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A start cycle stalls only for ops that will make the unit busy; MTHI/MTLO finish in one edge.
    assign busy     = (state_reg != ST_IDLE);
    assign md_stall = D_md_use & (busy | (start & is_run_op(md_op)));
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases plus randomized traffic against a behavioural model.
module tb_md_sched;
    import md_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        D_md_use = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: architectural HI/LO, the result waiting to land, and edges left until it lands.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    int          m_left = 0;

    md_sched #(.MUL_CYC(MUL_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .D_md_use (D_md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: results from 64-bit arithmetic, latency as a simple countdown.
    always @(posedge clk or negedge reset) begin
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            sa = longint'($signed(rs_val));
            sb = longint'($signed(rt_val));
            ua = {32'd0, rs_val};
            ub = {32'd0, rt_val};
            case (md_op)
                3'd0: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; m_left = MUL_N; end
                3'd1: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; m_left = MUL_N; end
                3'd2: begin
                    if (rt_val == 0) begin m_phi = m_hi; m_plo = m_lo; end
                    else begin sp = sa / sb; m_plo = sp[31:0]; sp = sa % sb; m_phi = sp[31:0]; end
                    m_left = DIV_N;
                end
                3'd3: begin
                    if (rt_val == 0) begin m_phi = m_hi; m_plo = m_lo; end
                    else begin up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0]; end
                    m_left = DIV_N;
                end
                3'd4: m_hi = rs_val;
                3'd5: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic exp_busy, exp_stall;
        exp_busy  = (m_left > 0);
        exp_stall = D_md_use && (exp_busy || (start && md_op <= 3'd3));
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("md_stall", {31'd0, md_stall}, {31'd0, exp_stall});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d);
        start = s; md_op = op; rs_val = a; rt_val = b; D_md_use = use_d;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    // Run a start pulse, check busy length and final HI/LO literals.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(1'b1, op, a, b, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < ncyc; i++) begin
            #2 check({name, "_busy"}, {31'd0, busy}, 32'd1);
            tick();
        end
        #2;
        check({name, "_done"}, {31'd0, busy}, 32'd0);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        // MULT -3*7 with D-stage HI/LO user: stall in start cycle and all busy cycles.
        drive(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        #2 check("t3_stall_start", {31'd0, md_stall}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < MUL_N; i++) begin
            #2 check("t1_busy", {31'd0, busy}, 32'd1);
            check("t3_stall_busy", {31'd0, md_stall}, 32'd1);
            tick();
        end
        #2;
        check("t3_stall_after", {31'd0, md_stall}, 32'd0);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFEB);
        tick();

        run_op("t2_divu", 3'd3, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);
        tick();
        run_op("t2_div", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        run_op("ovf_div", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);
        tick();

        // MTHI/MTLO setup, then divide by zero leaves HI/LO alone.
        drive(1'b1, 3'd4, 32'h11, 32'd0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        run_op("t4_div0", 3'd2, 32'd1234, 32'd0, DIV_N, 32'h11, 32'h22);
        tick();
        drive(1'b1, 3'd5, 32'h5, 32'd0, 1'b1);
        #2 check("t4_mtlo_stall", {31'd0, md_stall}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #2 check("t4_mtlo_lo", lo, 32'h5);
        check("t4_mtlo_busy", {31'd0, busy}, 32'd0);
        tick();

        // Async reset at cycle 3 of a DIV; the pending result must never appear.
        drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_hi", hi, 32'd0);
        check("t5_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        repeat (DIV_N + 2) tick();
        #2 check("t5_no_result_lo", lo, 32'd0);
        tick();

        // Second start mid-MULT is ignored.
        drive(1'b1, 3'd0, 32'd6, 32'd7, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b1, 3'd1, 32'd100, 32'd100, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        wait_idle("t6");
        #2 check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd42);
        tick();

        // Randomized traffic, including undefined ops, starts while busy and occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                  pick_val(), pick_val(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 299) == 0) begin
                #3 reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (DIV_N + 2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
